mem_upload_reader: RTL
======================

Name: mem_upload_reader

Overview:
- Read-side counterpart of the ROM/boot download writer. It serves HPS upload requests (ioctl read/upload) by fetching bytes from the zsdram port and returning them to hps_io.
- Index 0 uploads the ROM image, using the same 16 KB page map as the boot loader. Index 1 uploads a linear RAM dump.
- Sits in emu between hps_io and the zsdram address/oe mux. While `busy` is high, the top level routes `mem_rd`/`mem_addr` into zsdram.

Parameters:
- RAM_BASE, 9'h000, value of bank bits [22:14] for index-1 RAM dump page 0.
- RAM_PAGES, 8, number of 16 KB RAM pages for index 1; addresses beyond this read 8'hFF.
- FILL, 8'hFF, byte returned for unmapped addresses.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clkref  in  1  zsdram slot strobe (ce_ref), one-cycle pulse every 16 clk_sys.
- ioctl_upload  in  1  upload session active.
- ioctl_index  in  8  0 = ROM, 1 = RAM, others = unmapped.
- ioctl_rd  in  1  one-cycle read request.
- ioctl_addr  in  25  byte address, valid while ioctl_rd is high.
- ioctl_din  out  8  byte returned to hps_io.
- ioctl_wait  out  1  high while a fetch is pending.
- mem_rd  out  1  zsdram oe.
- mem_addr  out  23  zsdram address.
- mem_dout  in  8  zsdram read data.
- busy  out  1  high while ioctl_upload is high, or while the FSM is not in IDLE.
- overrun  out  1  sticky flag; set when ioctl_rd arrives while a fetch is pending.

Behaviour:
- Reset (async, while reset_n is low) forces: ioctl_din=8'hFF, ioctl_wait=0, mem_rd=0, mem_addr=0, overrun=0, FSM=IDLE.

Address map (combinational, evaluated on the ioctl_rd cycle, result registered):
- Index 0, page p=ioctl_addr[24:14]:
  - p=0 → bank 9'h000
  - p=1 → bank 9'h100
  - p=2 → bank 9'h107
  - otherwise unmapped.
- Index 1: page p < RAM_PAGES → bank RAM_BASE+p, otherwise unmapped.
- mem_addr = {bank, ioctl_addr[13:0]}.

FSM states: IDLE, ARM, ISSUE, CAPT.
- IDLE:
  - On ioctl_rd & ioctl_upload & mapped → latch mem_addr, set ioctl_wait=1 on the next edge, go to ARM.
  - On ioctl_rd & ioctl_upload & unmapped → ioctl_din=FILL and ioctl_wait stays 0. The result is available one cycle after ioctl_rd; no memory access is made.
  - ioctl_rd while ioctl_upload=0 is ignored.
- ARM: on clkref → mem_rd=1, go to ISSUE. The read is always aligned to a slot boundary.
- ISSUE: on the next clkref → mem_rd=0, go to CAPT.
- CAPT: one cycle later → ioctl_din=mem_dout, ioctl_wait=0, go to IDLE.
- Latency: from ioctl_rd to ioctl_wait falling is 17–33 clk_sys. mem_rd is high for exactly 16 cycles.
- ioctl_din holds its value until the next completed request.
- Each mapped ioctl_rd produces exactly one mem_rd window. No prefetch.

Boundary conditions:
- ioctl_rd while the FSM is not in IDLE: the request is ignored and overrun is set to 1. overrun clears only on reset or on a rising edge of ioctl_upload.
- ioctl_upload falls mid-fetch: on the next cycle → mem_rd=0, ioctl_wait=0, FSM=IDLE. ioctl_din keeps its last value.
- ioctl_rd on the same cycle as clkref: the request is latched and ARM waits for the following clkref. It does not issue in the same cycle.
- Page offset 16'h3FFF → 16'h4000 crosses into the next mapped bank with no gap.
- busy stays 1 for the whole session, so the zsdram mux must not return to the CPU until ioctl_upload falls and the FSM is in IDLE.

Test Plan:
- Index 0, ioctl_addr=0x00005, mem_dout model returns 0xA5 at 23'h000005 → mem_addr=23'h000005, mem_rd high for 16 cycles starting on a clkref, ioctl_din=0xA5, ioctl_wait falls ≤33 cycles after ioctl_rd.
- Index 0, ioctl_addr=0x04010 and 0x08010 → mem_addr=23'h400010 and 23'h41C010 respectively; ioctl_addr=0x0C000 → ioctl_din=0xFF, ioctl_wait never asserts, mem_rd never asserts.
- Index 1 with RAM_PAGES=8, ioctl_addr=0x1FFFF → mem_addr={RAM_BASE+7,14'h3FFF}; ioctl_addr=0x20000 → ioctl_din=0xFF.
- Second ioctl_rd issued 5 cycles after the first → overrun=1, only one mem_rd window, ioctl_din equals the first byte; a new ioctl_upload rising edge clears overrun.
- Drop ioctl_upload while in ISSUE → mem_rd=0 and ioctl_wait=0 on the next cycle, FSM in IDLE, busy=0.
- Assert reset_n=0 asynchronously mid-fetch (not on a clock edge) → all outputs at their reset values immediately; after release, a fresh request completes normally.

Source files
------------

// File: rtl/mem_upload_reader_if.sv
// mem_upload_reader_if: hps_io upload handshake plus zsdram read port
interface mem_upload_reader_if;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_rd;
  logic [22:0] mem_addr;
  logic [7:0]  mem_dout;
  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_dout,
    input  ioctl_din, ioctl_wait, mem_rd, mem_addr
  );
  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, mem_dout,
    output ioctl_din, ioctl_wait, mem_rd, mem_addr
  );
endinterface

// File: rtl/mem_upload_reader.sv
// mem_upload_reader: serves hps_io upload reads (ROM page map / linear RAM dump) from zsdram, slot-aligned
module mem_upload_reader #(
  parameter logic [8:0] RAM_BASE  = 9'h000,
  parameter int         RAM_PAGES = 8,
  parameter logic [7:0] FILL      = 8'hFF
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               clkref,
  mem_upload_reader_if.slave bus,
  output logic               busy,
  output logic               overrun
);
  typedef enum logic [1:0] {IDLE, ARM, ISSUE, CAPT} state_t;
  localparam logic [10:0] RAM_PG = 11'(RAM_PAGES);
  state_t      state_q, state_d;
  logic [7:0]  din_q, din_d;
  logic [22:0] addr_q, addr_d;
  logic        wait_q, wait_d, rd_q, rd_d, ovr_q, ovr_d, upl_q;
  logic [10:0] page;
  logic [8:0]  bank;
  logic        mapped;
  always_comb begin
    page   = bus.ioctl_addr[24:14];
    bank   = bus.ioctl_index == 8'd0 ? (page == 11'd0 ? 9'h000 : page == 11'd1 ? 9'h100 : 9'h107)
                                     : RAM_BASE + page[8:0];
    mapped = bus.ioctl_index == 8'd0 ? page < 11'd3 : (bus.ioctl_index == 8'd1) && (page < RAM_PG);
  end
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    rd_d    = rd_q;
    // a fresh session clears the sticky flag before a new overrun can set it
    ovr_d   = (ovr_q & ~(bus.ioctl_upload & ~upl_q)) |
              (bus.ioctl_upload & bus.ioctl_rd & (state_q != IDLE));
    if (!bus.ioctl_upload) begin
      state_d = IDLE;
      wait_d  = 1'b0;
      rd_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.ioctl_rd) begin
          state_d = mapped ? ARM : IDLE;
          wait_d  = mapped;
          addr_d  = mapped ? {bank, bus.ioctl_addr[13:0]} : addr_q;
          din_d   = mapped ? din_q : FILL;
        end
        ARM: if (clkref) begin
          state_d = ISSUE;
          rd_d    = 1'b1;
        end
        ISSUE: if (clkref) begin
          state_d = CAPT;
          rd_d    = 1'b0;
        end
        default: begin
          state_d = IDLE;
          din_d   = bus.mem_dout;
          wait_d  = 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      din_q   <= 8'hFF;
      addr_q  <= '0;
      wait_q  <= 1'b0;
      rd_q    <= 1'b0;
      ovr_q   <= 1'b0;
      upl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
      ovr_q   <= ovr_d;
      upl_q   <= bus.ioctl_upload;
    end
  end
  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.mem_rd     = rd_q;
  assign bus.mem_addr   = addr_q;
  assign overrun        = ovr_q;
  assign busy           = bus.ioctl_upload | (state_q != IDLE);
endmodule
